// File: rtl/dmem_bridge_if.sv
// dmem_bridge_if: word-addressed ready/valid SRAM port.
// master = bridge side, slave = memory side.
interface dmem_bridge_if #(
  parameter int ADDR_W = 11
) ();
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_be,
    output mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_be,
    input  mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/dmem_bridge.sv
// dmem_bridge: core load/store to byte-enabled SRAM port.
// Stalls the core per access, flags bad/timed-out accesses.
module dmem_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int          ADDR_W    = 11,
  parameter int          TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DM_E,
  input  logic        DM_R,
  input  logic        DM_W,
  input  logic [1:0]  opt,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        acc_err,
  output logic        bus_err,
  dmem_bridge_if.master mem
);

  localparam int CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE, BUSY, DONE, ERR
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              acc_q;
  logic              bus_q;
  logic              word_q;
  logic              half_q;
  logic [1:0]        lane_q;

  logic [31:0] off;
  logic        is_word;
  logic        is_half;
  logic        illegal;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] rext_d;

  // Load is simply "not a store"; the low offset bits
  // duplicate addr[1:0] when the base is word aligned.
  logic [2:0] unused_sig;
  assign unused_sig = {DM_R, off[1:0]};

  assign off     = addr - BASE_ADDR;
  assign is_word = opt[1];
  assign is_half = (opt == 2'b01);
  assign illegal = (is_half & addr[0])
                 | (is_word & (|addr[1:0]))
                 | (|off[31:ADDR_W+2]);

  // Store lane steering; loads read the whole word.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = wdata;
    if (DM_W) begin
      unique case (1'b1)
        is_word: ;
        is_half: begin
          be_d    = 4'b0011 << {addr[1], 1'b0};
          wdata_d = {2{wdata[15:0]}};
        end
        default: begin
          be_d    = 4'b0001 << addr[1:0];
          wdata_d = {4{wdata[7:0]}};
        end
      endcase
    end
  end

  // Right-justify the addressed lane of the read word.
  always_comb begin
    rext_d = mem.mem_rdata;
    unique case (1'b1)
      word_q: rext_d = mem.mem_rdata;
      half_q: rext_d = {16'h0,
        mem.mem_rdata[{lane_q[1], 4'b0000} +: 16]};
      default: rext_d = {24'h0,
        mem.mem_rdata[{lane_q, 3'b000} +: 8]};
    endcase
  end

  // Access FSM with registered bus and status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      acc_q   <= 1'b0;
      bus_q   <= 1'b0;
      word_q  <= 1'b0;
      half_q  <= 1'b0;
      lane_q  <= 2'b0;
    end else begin
      acc_q <= 1'b0;
      bus_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (DM_E) begin
            if (illegal) begin
              state_q <= ERR;
              acc_q   <= 1'b1;
              rdata_q <= 32'h0;
            end else begin
              state_q <= BUSY;
              cnt_q   <= '0;
              req_q   <= 1'b1;
              we_q    <= DM_W;
              be_q    <= be_d;
              addr_q  <= off[ADDR_W+1:2];
              wdata_q <= wdata_d;
              word_q  <= is_word;
              half_q  <= is_half;
              lane_q  <= addr[1:0];
            end
          end
        end
        BUSY: begin
          if (mem.mem_ready) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            rdata_q <= rext_d;
          end else if (cnt_q == TMO) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            rdata_q <= 32'h0;
            bus_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall = rst & DM_E
               & ((state_q == IDLE) | (state_q == BUSY));

  assign rdata         = rdata_q;
  assign acc_err       = acc_q;
  assign bus_err       = bus_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed checks of the data-memory bridge.
// One task per scenario, each with its own comparisons.
module tb_dmem_bridge;

  logic        clk;
  logic        rst;
  logic        DM_E;
  logic        DM_R;
  logic        DM_W;
  logic [1:0]  opt;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        acc_err;
  logic        bus_err;

  int n_chk;
  int n_fail;

  dmem_bridge_if #(.ADDR_W(11)) mif ();

  dmem_bridge #(
    .BASE_ADDR(32'h1001_0000),
    .ADDR_W(11),
    .TIMEOUT(255)
  ) dut (
    .clk(clk),
    .rst(rst),
    .DM_E(DM_E),
    .DM_R(DM_R),
    .DM_W(DM_W),
    .opt(opt),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .stall(stall),
    .acc_err(acc_err),
    .bus_err(bus_err),
    .mem(mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observations from the last access.
  int          o_stalls;
  logic        o_req;
  logic [10:0] o_addr;
  logic [3:0]  o_be;
  logic        o_we;
  logic [31:0] o_wd;
  logic [31:0] o_rd;
  logic        o_acc;
  logic        o_bus;
  logic        o_stable;

  // Drives one access from an IDLE cycle (posedge+1) and
  // plays memory: ready after wait_n busy cycles, never if <0.
  task automatic run_access(
    input logic r, input logic w, input logic [1:0] op,
    input logic [31:0] a, input logic [31:0] wd,
    input logic [31:0] mrd, input int wait_n
  );
    int  k;
    bit  fin;
    k = 0;
    fin = 0;
    o_stalls = 0;
    o_req = 0;
    o_stable = 1;
    o_addr = '0; o_be = '0; o_we = 0; o_wd = '0;
    DM_E = 1; DM_R = r; DM_W = w;
    opt = op; addr = a; wdata = wd;
    mif.mem_ready = 0;
    mif.mem_rdata = 32'h0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      if (stall) o_stalls++;
      if (mif.mem_req) begin
        if (!o_req) begin
          o_req  = 1;
          o_addr = mif.mem_addr;
          o_be   = mif.mem_be;
          o_we   = mif.mem_we;
          o_wd   = mif.mem_wdata;
        end else if ({o_addr, o_be, o_we, o_wd} !==
                     {mif.mem_addr, mif.mem_be,
                      mif.mem_we, mif.mem_wdata}) begin
          o_stable = 0;
        end
        mif.mem_ready = (wait_n >= 0 && k == wait_n);
        mif.mem_rdata = mrd;
        k++;
      end else begin
        mif.mem_ready = 0;
      end
      if (!stall) begin
        o_rd  = rdata;
        o_acc = acc_err;
        o_bus = bus_err;
        fin   = 1;
      end
    end
    if (!fin) begin
      n_fail++;
      $display("FAIL access_bound: no completion in 400 cycles");
    end
    DM_E = 0;
    mif.mem_ready = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 0; DM_E = 1; DM_R = 1; DM_W = 1;
    opt = 2'b11; addr = 32'h1001_0000; wdata = 32'hFFFF_FFFF;
    mif.mem_ready = 1; mif.mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (mif.mem_req !== 1'b0) begin n_fail++;
      $display("FAIL rst_req: got %b want 0", mif.mem_req); end
    n_chk++; if (mif.mem_we !== 1'b0) begin n_fail++;
      $display("FAIL rst_we: got %b want 0", mif.mem_we); end
    n_chk++; if (mif.mem_be !== 4'h0) begin n_fail++;
      $display("FAIL rst_be: got %h want 0", mif.mem_be); end
    n_chk++; if (mif.mem_addr !== 11'h0) begin n_fail++;
      $display("FAIL rst_addr: got %h want 0", mif.mem_addr); end
    n_chk++; if (mif.mem_wdata !== 32'h0) begin n_fail++;
      $display("FAIL rst_wdata: got %h want 0", mif.mem_wdata); end
    n_chk++; if (rdata !== 32'h0) begin n_fail++;
      $display("FAIL rst_rdata: got %h want 0", rdata); end
    n_chk++; if ({acc_err, bus_err} !== 2'b00) begin n_fail++;
      $display("FAIL rst_err: got %b want 00", {acc_err, bus_err}); end
    n_chk++; if (stall !== 1'b0) begin n_fail++;
      $display("FAIL rst_stall: got %b want 0", stall); end
    @(posedge clk);
    #1;
    rst = 1; DM_E = 0; DM_R = 0; DM_W = 0;
    mif.mem_ready = 0;
  endtask

  task automatic test_word;
    run_access(0, 1, 2'b11, 32'h1001_0008, 32'hA5A5_1234, 32'h0, 0);
    n_chk++; if (o_addr !== 11'd2) begin n_fail++;
      $display("FAIL sw_addr: got %h want 2", o_addr); end
    n_chk++; if (o_be !== 4'b1111 || o_we !== 1'b1) begin n_fail++;
      $display("FAIL sw_be_we: got %b/%b want 1111/1", o_be, o_we); end
    n_chk++; if (o_wd !== 32'hA5A5_1234) begin n_fail++;
      $display("FAIL sw_wdata: got %h want a5a51234", o_wd); end
    run_access(1, 0, 2'b11, 32'h1001_0008, 32'h0, 32'hA5A5_1234, 0);
    n_chk++; if (o_rd !== 32'hA5A5_1234) begin n_fail++;
      $display("FAIL lw_rdata: got %h want a5a51234", o_rd); end
    n_chk++; if (o_stalls != 2) begin n_fail++;
      $display("FAIL lw_stall: got %0d want 2", o_stalls); end
    n_chk++; if (o_be !== 4'b1111 || o_we !== 1'b0) begin n_fail++;
      $display("FAIL lw_be_we: got %b/%b want 1111/0", o_be, o_we); end
  endtask

  task automatic test_byte;
    run_access(0, 1, 2'b00, 32'h1001_0003, 32'h0000_00EF, 32'h0, 0);
    n_chk++; if (o_be !== 4'b1000) begin n_fail++;
      $display("FAIL sb_be: got %b want 1000", o_be); end
    n_chk++; if (o_wd !== 32'hEFEF_EFEF) begin n_fail++;
      $display("FAIL sb_wdata: got %h want efefefef", o_wd); end
    run_access(1, 0, 2'b00, 32'h1001_0003, 32'h0, 32'hEF00_0000, 0);
    n_chk++; if (o_rd !== 32'h0000_00EF) begin n_fail++;
      $display("FAIL lb3_rdata: got %h want 000000ef", o_rd); end
    run_access(1, 0, 2'b00, 32'h1001_0001, 32'h0, 32'h1234_5678, 0);
    n_chk++; if (o_rd !== 32'h0000_0056) begin n_fail++;
      $display("FAIL lb1_rdata: got %h want 00000056", o_rd); end
  endtask

  task automatic test_half;
    run_access(1, 0, 2'b01, 32'h1001_0002, 32'h0, 32'h8001_0000, 0);
    n_chk++; if (o_rd !== 32'h0000_8001) begin n_fail++;
      $display("FAIL lh2_rdata: got %h want 00008001", o_rd); end
    run_access(1, 0, 2'b01, 32'h1001_0000, 32'h0, 32'h8001_7FFE, 0);
    n_chk++; if (o_rd !== 32'h0000_7FFE) begin n_fail++;
      $display("FAIL lh0_rdata: got %h want 00007ffe", o_rd); end
    run_access(0, 1, 2'b01, 32'h1001_0002, 32'hFFFF_BEEF, 32'h0, 0);
    n_chk++; if (o_be !== 4'b1100 || o_wd !== 32'hBEEF_BEEF) begin
      n_fail++;
      $display("FAIL sh_be_wd: got %b/%h want 1100/beefbeef",
               o_be, o_wd); end
    run_access(1, 0, 2'b01, 32'h1001_0001, 32'h0, 32'h1111_1111, 0);
    n_chk++; if (o_acc !== 1'b1 || o_req !== 1'b0) begin n_fail++;
      $display("FAIL lh1_err: got acc=%b req=%b want 1/0",
               o_acc, o_req); end
    n_chk++; if (o_rd !== 32'h0 || o_stalls != 1) begin n_fail++;
      $display("FAIL lh1_rd_stall: got %h/%0d want 0/1",
               o_rd, o_stalls); end
  endtask

  task automatic test_range;
    run_access(1, 0, 2'b11, 32'h1000_FFFC, 32'h0, 32'h0, 0);
    n_chk++; if (o_acc !== 1'b1 || o_req !== 1'b0) begin n_fail++;
      $display("FAIL oor_low: got acc=%b req=%b want 1/0",
               o_acc, o_req); end
    run_access(1, 0, 2'b11, 32'h1001_2000, 32'h0, 32'h0, 0);
    n_chk++; if (o_acc !== 1'b1 || o_req !== 1'b0) begin n_fail++;
      $display("FAIL oor_high: got acc=%b req=%b want 1/0",
               o_acc, o_req); end
    run_access(1, 0, 2'b11, 32'h1001_1FFC, 32'h0, 32'h0BAD_F00D, 0);
    n_chk++; if (o_acc !== 1'b0 || o_addr !== 11'h7FF) begin
      n_fail++;
      $display("FAIL last_word: got acc=%b addr=%h want 0/7ff",
               o_acc, o_addr); end
    run_access(0, 1, 2'b11, 32'h1001_0006, 32'h1, 32'h0, 0);
    n_chk++; if (o_acc !== 1'b1 || o_req !== 1'b0) begin n_fail++;
      $display("FAIL sw_mis: got acc=%b req=%b want 1/0",
               o_acc, o_req); end
  endtask

  task automatic test_wait;
    run_access(1, 0, 2'b11, 32'h1001_0040, 32'h0, 32'h1357_9BDF, 3);
    n_chk++; if (o_stalls != 5) begin n_fail++;
      $display("FAIL wait_stall: got %0d want 5", o_stalls); end
    n_chk++; if (o_stable !== 1'b1) begin n_fail++;
      $display("FAIL wait_stable: got %b want 1", o_stable); end
    n_chk++; if (o_rd !== 32'h1357_9BDF || o_addr !== 11'h10) begin
      n_fail++;
      $display("FAIL wait_rd: got %h/%h want 13579bdf/010",
               o_rd, o_addr); end
  endtask

  task automatic test_timeout;
    run_access(1, 0, 2'b11, 32'h1001_0004, 32'h0, 32'hFFFF_FFFF, -1);
    n_chk++; if (o_bus !== 1'b1 || o_acc !== 1'b0) begin n_fail++;
      $display("FAIL tmo_err: got bus=%b acc=%b want 1/0",
               o_bus, o_acc); end
    n_chk++; if (o_stalls != 257) begin n_fail++;
      $display("FAIL tmo_stall: got %0d want 257", o_stalls); end
    n_chk++; if (o_rd !== 32'h0 || o_stable !== 1'b1) begin n_fail++;
      $display("FAIL tmo_rd: got %h stable=%b want 0/1",
               o_rd, o_stable); end
    @(negedge clk);
    n_chk++; if (bus_err !== 1'b0 || mif.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_after: got bus=%b req=%b want 0/0",
               bus_err, mif.mem_req); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    run_access(0, 1, 2'b10, 32'h1001_0004, 32'h1122_3344, 32'h0, 0);
    n_chk++; if (o_be !== 4'b1111 || o_wd !== 32'h1122_3344 ||
                 o_addr !== 11'd1) begin n_fail++;
      $display("FAIL opt10: got %b/%h/%h want 1111/11223344/001",
               o_be, o_wd, o_addr); end
    run_access(1, 1, 2'b00, 32'h1001_0005, 32'h0000_0077, 32'h0, 0);
    n_chk++; if (o_we !== 1'b1 || o_be !== 4'b0010 ||
                 o_stalls != 2) begin n_fail++;
      $display("FAIL rw_store: got we=%b be=%b st=%0d want 1/0010/2",
               o_we, o_be, o_stalls); end
    run_access(1, 0, 2'b11, 32'h1001_000C, 32'h0, 32'hCAFE_0001, 1);
    n_chk++; if (o_rd !== 32'hCAFE_0001 || o_stalls != 3) begin
      n_fail++;
      $display("FAIL b2b_load: got %h/%0d want cafe0001/3",
               o_rd, o_stalls); end
  endtask

  task automatic test_reset_mid_busy;
    DM_E = 1; DM_R = 1; DM_W = 0;
    opt = 2'b11; addr = 32'h1001_0010;
    mif.mem_ready = 0;
    @(posedge clk); #1;
    n_chk++; if (mif.mem_req !== 1'b1) begin n_fail++;
      $display("FAIL mid_busy_req: got %b want 1", mif.mem_req); end
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk);
    @(negedge clk);
    n_chk++; if (mif.mem_req !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst: got req=%b stall=%b want 0/0",
               mif.mem_req, stall); end
    n_chk++; if (rdata !== 32'h0) begin n_fail++;
      $display("FAIL mid_rst_rdata: got %h want 0", rdata); end
    @(posedge clk); #1;
    rst = 1; DM_E = 0;
    mif.mem_ready = 1; mif.mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mif.mem_ready = 0;
    @(negedge clk);
    n_chk++; if (rdata !== 32'h0 || bus_err !== 1'b0 ||
                 mif.mem_req !== 1'b0) begin n_fail++;
      $display("FAIL late_ready: got rd=%h bus=%b req=%b want 0/0/0",
               rdata, bus_err, mif.mem_req); end
    @(posedge clk); #1;
    run_access(1, 0, 2'b11, 32'h1001_0010, 32'h0, 32'h0F0F_0F0F, 0);
    n_chk++; if (o_rd !== 32'h0F0F_0F0F || o_stalls != 2) begin
      n_fail++;
      $display("FAIL post_rst: got %h/%0d want 0f0f0f0f/2",
               o_rd, o_stalls); end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_range();
    test_wait();
    test_timeout();
    test_back_to_back();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
